alu_instr_encoder: RTL and testbench
====================================

# alu_instr_encoder

Sequential inverse of the decode-stage ALU decoder. It accepts an ALU operation request (`ALU_OP` class, ALU control code, register indices, immediate) over a valid/ready handshake and builds the 32-bit RV32I OP or OP-IMM instruction word. Encoded words go through a small output FIFO with its own valid/ready handshake. It sits in the test and program-generation path ahead of instruction memory, and round-trips words through the decode stage for self-checking.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request can be accepted this cycle.
- `in_alu_op` input 2: `ALU_OP_ARITHM_REG` or `ALU_OP_ARITHM_IMM`.
- `in_alu_ctrl` input 3: one of `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices; `in_rs2` is ignored for IMM.
- `in_imm` input 12: I-type immediate; ignored for REG.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer takes the head.
- `out_instr` output 32: FIFO head word.
- `err` output 1: one-cycle pulse when an illegal request is rejected.
- `err_cnt` output 8: present only with `ALU_ENC_ERRCNT_EN`.

## Operation
- Acceptance occurs when `in_valid && in_ready`.
- On acceptance, stage register S1 captures the encoded word and a legality bit.
- Encoding:
  - REG: opcode 0110011, `funct7`/`rs2`/`rs1`/`funct3`/`rd` packed in the standard R-type layout.
  - IMM: opcode 0010011, `in_imm[11:0]` in bits 31:20.
- `funct3` by operation: ADD/SUB 000, XOR 100, OR 110, AND 111.
- `funct7`: 0100000 for SUB, otherwise 0000000.
- Illegal requests:
  - `ALU_SUB` with IMM (no SUBI exists).
  - Any `in_alu_ctrl` outside the five codes.
  - Any `in_alu_op` other than REG or IMM.
- Illegal requests are consumed, never written to the FIFO, and raise `err` for one cycle.
- S1 to FIFO: a valid legal S1 entry is pushed on the next edge. S1 never stalls, because `in_ready` reserves space for it in advance.
- `in_ready = (fifo_count + s1_valid) < DEPTH`. The value is combinational from registers only, with no path from `in_valid`.
- FIFO behaviour:
  - Circular buffer; read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
  - Pop on `out_valid && out_ready`.
  - A push and a pop in the same cycle leave the count unchanged, even when full.
- `out_instr` is driven from the head entry. Its contents are don't-care while `out_valid` is 0.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `out_instr` 0, `err` 0, `err_cnt` 0. Pointers, count, and `s1_valid` all reset to 0.
- Reset asserted mid-operation: all queued words and S1 are discarded immediately (asynchronously). No partial word appears after release.
- Latency for a request accepted at edge N:
  - The word is in S1 after edge N.
  - It is in the FIFO, and `out_valid` is 1 with an empty FIFO, after edge N+1.
  - Minimum latency is 2 cycles.
- An illegal request accepted at edge N drives `err` to 1 for exactly the cycle after edge N.
- Sustained throughput is one word per cycle while `out_ready` is held at 1.
- Full condition: `in_ready` drops in the cycle where count + `s1_valid` equals `DEPTH`. It returns to 1 in the cycle after the pop edge that frees an entry.
- Empty condition: `out_valid` is 0. `out_ready` has no effect.

## Configuration
- `ALU_ENC_ERRCNT_EN` defined: the `err_cnt` port exists.
  - 8-bit counter of rejected requests.
  - Increments on each illegal acceptance and saturates at 255.
  - Cleared only by `rst_n`.
- `ALU_ENC_ERRCNT_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Structure
- Add to `Constants.v`, next to the existing `ALU_OP_*` and `ALU_*` codes:
  - Opcode constants `OPCODE_OP` (0110011) and `OPCODE_OP_IMM` (0010011).
  - `funct3` constants for ADD, XOR, OR, AND.
  - `funct7` constants `FUNCT7_BASE` and `FUNCT7_ALT`.
- One sub-module, `instr_fifo`: parameterised by `DEPTH` and width, asynchronous active-low reset, exposes count.
- Encoding and legality logic live in the top module.

## Test plan
- REG `ALU_ADD` with rd=3, rs1=1, rs2=2, `out_ready`=1 → `out_instr` = 0x002081B3 with `out_valid` high 2 cycles after acceptance.
- REG `ALU_SUB` with rd=5, rs1=6, rs2=7 → 0x407302B3. Then IMM `ALU_ADD` with rd=1, rs1=0, imm=0xFFF → 0xFFF00093, with order preserved.
- IMM `ALU_XOR` with rd=2, rs1=1, imm=5 → 0x0050C113.
- IMM `ALU_SUB` → `err` high for 1 cycle and nothing emitted. With `ALU_ENC_ERRCNT_EN`, `err_cnt` = 1; after 300 illegal requests, `err_cnt` = 255.
- Hold `out_ready`=0 and stream 6 legal requests → exactly 4 accepted and `in_ready` = 0. Raise `out_ready` → the 4 words come out in order and `in_ready` returns to 1 one cycle after the first pop.
- With 3 words queued, pulse `rst_n` low for 1 cycle → `out_valid` = 0 and `in_ready` = 1 immediately. No stale word appears afterwards.

Source files
------------

// File: rtl/alu_instr_encoder_pkg.sv
// Shared ALU request codes and RV32I OP/OP-IMM field constants for the ALU instruction encoder.
package alu_instr_encoder_pkg;

  // ALU operation class, as produced by the decode-stage ALU decoder
  localparam logic [1:0] ALU_OP_ARITHM_REG = 2'b00;
  localparam logic [1:0] ALU_OP_ARITHM_IMM = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_XOR = 3'b100;
  localparam logic [2:0] FUNCT3_OR  = 3'b110;
  localparam logic [2:0] FUNCT3_AND = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // S1 stage contents: encoded word plus legality
  typedef struct packed {
    logic        vld;
    logic        legal;
    logic [31:0] word;
  } s1_t;

endpackage

// File: rtl/alu_instr_encoder_fifo.sv
// instr_fifo: circular-buffer FIFO with exposed count; async active-low reset.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic push_ok, pop_ok;

  assign pop_ok  = pop && (count != '0);
  // A push into a full FIFO is only accepted when a pop frees the head in the same cycle
  assign push_ok = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// ALU request -> RV32I OP/OP-IMM word encoder with S1 stage and output FIFO.
// Optional saturating reject counter on err_cnt when ALU_ENC_ERRCNT_EN is defined.
module alu_instr_encoder
  import alu_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_alu_op,
  input  logic [2:0]  in_alu_ctrl,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [11:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef ALU_ENC_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  s1_t           s1;
  logic [AW:0]   fifo_count;
  logic [AW+1:0] occ;
  logic          accept, legal;
  logic [31:0]   word;
  logic [2:0]    f3;
  logic [6:0]    f7;

  // Reserving the S1 slot up front means S1 can always drain into the FIFO
  assign occ      = {1'b0, fifo_count} + {{(AW+1){1'b0}}, s1.vld};
  assign in_ready = occ < (AW+2)'(DEPTH);
  assign accept   = in_valid && in_ready;
  assign out_valid = fifo_count != '0;

  always_comb begin
    f3    = FUNCT3_ADD;
    f7    = FUNCT7_BASE;
    legal = 1'b1;
    word  = '0;
    case (in_alu_ctrl)
      ALU_ADD: f3 = FUNCT3_ADD;
      ALU_SUB: f7 = FUNCT7_ALT;
      ALU_AND: f3 = FUNCT3_AND;
      ALU_OR:  f3 = FUNCT3_OR;
      ALU_XOR: f3 = FUNCT3_XOR;
      default: legal = 1'b0;
    endcase
    case (in_alu_op)
      ALU_OP_ARITHM_REG: word = {f7, in_rs2, in_rs1, f3, in_rd, OPCODE_OP};
      ALU_OP_ARITHM_IMM: begin
        word = {in_imm, in_rs1, f3, in_rd, OPCODE_OP_IMM};
        if (in_alu_ctrl == ALU_SUB) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      err <= 1'b0;
    end else begin
      s1.vld   <= accept;
      s1.legal <= legal;
      s1.word  <= word;
      err      <= accept && !legal;
    end
  end

`ifdef ALU_ENC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_cnt <= '0;
    else if (accept && !legal && err_cnt != 8'hFF)  err_cnt <= err_cnt + 1'b1;
  end
`endif

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1.vld && s1.legal),
    .din   (s1.word),
    .pop   (out_ready),
    .dout  (out_instr),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomized + directed bench for alu_instr_encoder against a queue-based reference model.
module tb_alu_instr_encoder;
  import alu_instr_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_alu_op = '0;
  logic [2:0]  in_alu_ctrl = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        err;
`ifdef ALU_ENC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_pass = 0, n_total = 0;

  alu_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef ALU_ENC_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Reference encoding straight from the ISA field table, using plain arithmetic
  function automatic void ref_encode(input logic [1:0] op, input logic [2:0] c,
                                     input logic [4:0] rd, rs1, rs2, input logic [11:0] imm,
                                     output logic [31:0] w, output bit ok);
    longint f3 = 0, f7 = 0, v = 0;
    ok = 1;
    case (c)
      ALU_ADD: f3 = 0;
      ALU_SUB: begin f3 = 0; f7 = 32; end
      ALU_XOR: f3 = 4;
      ALU_OR:  f3 = 6;
      ALU_AND: f3 = 7;
      default: ok = 0;
    endcase
    if (op == ALU_OP_ARITHM_REG)
      v = f7 * 2**25 + longint'(rs2) * 2**20 + longint'(rs1) * 2**15 + f3 * 4096 + longint'(rd) * 128 + 51;
    else if (op == ALU_OP_ARITHM_IMM) begin
      v = longint'(imm) * 2**20 + longint'(rs1) * 2**15 + f3 * 4096 + longint'(rd) * 128 + 19;
      if (c == ALU_SUB) ok = 0;
    end else ok = 0;
    w = v[31:0];
  endfunction

  // Behavioural model: queue of words plus one-cycle staging slot
  logic [31:0] q[$];
  bit          m_s1v, m_s1l, m_err;
  logic [31:0] m_s1w;
  int          m_errcnt;

  function automatic bit m_ready();
    return (q.size() + int'(m_s1v)) < DEPTH;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); m_s1v = 0; m_s1l = 0; m_err = 0; m_errcnt = 0;
    end else begin
      bit acc, ok;
      logic [31:0] w;
      acc = in_valid && m_ready();
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (m_s1v && m_s1l) q.push_back(m_s1w);
      ref_encode(in_alu_op, in_alu_ctrl, in_rd, in_rs1, in_rs2, in_imm, w, ok);
      m_s1v = acc; m_s1w = w; m_s1l = ok;
      m_err = acc && !ok;
      if (m_err && m_errcnt < 255) m_errcnt++;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) chk("out_instr", out_instr, q[0]);
      chk("err", {31'd0, err}, {31'd0, m_err});
`ifdef ALU_ENC_ERRCNT_EN
      chk("err_cnt", {24'd0, err_cnt}, m_errcnt);
`endif
    end
  end

  task automatic set_req(input logic [1:0] op, input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                         input logic [11:0] imm);
    in_alu_op = op; in_alu_ctrl = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge
  task automatic send(input logic [1:0] op, input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                      input logic [11:0] imm);
    bit done = 0;
    set_req(op, c, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int acc;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
`ifdef ALU_ENC_ERRCNT_EN
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // REG ADD, latency 2
    out_ready = 1'b1;
    send(ALU_OP_ARITHM_REG, ALU_ADD, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("add_lat1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_word", out_instr, 32'h002081B3);
    @(negedge clk);

    // SUB then ADDI, order preserved
    out_ready = 1'b0;
    send(ALU_OP_ARITHM_REG, ALU_SUB, 5'd5, 5'd6, 5'd7, 12'd0);
    send(ALU_OP_ARITHM_IMM, ALU_ADD, 5'd1, 5'd0, 5'd0, 12'hFFF);
    @(negedge clk);
    chk("sub_word", out_instr, 32'h407302B3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("addi_word", out_instr, 32'hFFF00093);
    @(negedge clk);

    // XORI
    send(ALU_OP_ARITHM_IMM, ALU_XOR, 5'd2, 5'd1, 5'd0, 12'd5);
    @(negedge clk);
    chk("xori_word", out_instr, 32'h0050C113);
    @(negedge clk);
    chk("xori_drained", {31'd0, out_valid}, 32'd0);

    // IMM SUB rejected
    send(ALU_OP_ARITHM_IMM, ALU_SUB, 5'd4, 5'd4, 5'd0, 12'd1);
    chk("subi_err", {31'd0, err}, 32'd1);
`ifdef ALU_ENC_ERRCNT_EN
    chk("subi_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
    @(negedge clk);
    chk("subi_err_pulse", {31'd0, err}, 32'd0);
    chk("subi_no_word", {31'd0, out_valid}, 32'd0);

    // full: six offered with out_ready low, four taken
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(ALU_OP_ARITHM_REG, ALU_OR, 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'd0);
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_accepted", acc, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_back", {31'd0, in_ready}, 32'd1);
    drain();

    // async reset with three queued words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(ALU_OP_ARITHM_REG, ALU_AND, 5'd9, 5'(i), 5'd1, 12'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      set_req(($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
              5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

`ifdef ALU_ENC_ERRCNT_EN
    set_req(ALU_OP_ARITHM_IMM, ALU_SUB, 5'd1, 5'd1, 5'd0, 12'd0);
    in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
